// File: rtl/divisor_arbitro_2req.sv
// Two-port round-robin front end for a shared 4-bit sequential divider.
// Divide-by-zero is answered locally; a hung divider is aborted after TIMEOUT_CYC wait cycles.
module divisor_arbitro_2req #(
   parameter int DATA_W      = 4,
   parameter int TIMEOUT_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_dividendo,
   input  logic [DATA_W-1:0] req0_divisor,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_dividendo,
   input  logic [DATA_W-1:0] req1_divisor,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_quociente,
   output logic [DATA_W-1:0] resp_resto,
   output logic              resp_dz,
   output logic              resp_err,
   output logic              div_start,
   output logic [DATA_W-1:0] div_dividendo,
   output logic [DATA_W-1:0] div_divisor,
   input  logic [DATA_W-1:0] div_quociente,
   input  logic [DATA_W-1:0] div_resto,
   input  logic              div_done,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t             state;
   logic               last_grant;
   logic [CNT_W-1:0]   wait_cnt;
   logic               grant_any;
   logic               grant_id;
   logic               accept;
   logic [DATA_W-1:0]  sel_dividendo;
   logic [DATA_W-1:0]  sel_divisor;

   // On a tie the port that did not win last time gets the divider.
   assign grant_any     = req0_valid | req1_valid;
   assign grant_id      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign accept        = rst && (state == IDLE) && grant_any;
   assign req0_ready    = accept && !grant_id;
   assign req1_ready    = accept && grant_id;
   assign sel_dividendo = grant_id ? req1_dividendo : req0_dividendo;
   assign sel_divisor   = grant_id ? req1_divisor   : req0_divisor;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         wait_cnt       <= '0;
         resp_valid     <= 1'b0;
         resp_id        <= 1'b0;
         resp_quociente <= '0;
         resp_resto     <= '0;
         resp_dz        <= 1'b0;
         resp_err       <= 1'b0;
         div_start      <= 1'b0;
         div_dividendo  <= '0;
         div_divisor    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  last_grant    <= grant_id;
                  resp_id       <= grant_id;
                  div_dividendo <= sel_dividendo;
                  div_divisor   <= sel_divisor;
                  if (sel_divisor == '0) begin
                     resp_quociente <= '1;
                     resp_resto     <= sel_dividendo;
                     resp_dz        <= 1'b1;
                     resp_err       <= 1'b0;
                     resp_valid     <= 1'b1;
                     state          <= RESP;
                  end else begin
                     div_start <= 1'b1;
                     state     <= START;
                  end
               end
            end
            // div_done may linger from the previous operation, so it is not looked at here.
            START: begin
               div_start <= 1'b0;
               wait_cnt  <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (div_done) begin
                  resp_quociente <= div_quociente;
                  resp_resto     <= div_resto;
                  resp_dz        <= 1'b0;
                  resp_err       <= 1'b0;
                  resp_valid     <= 1'b1;
                  state          <= RESP;
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  resp_quociente <= '0;
                  resp_resto     <= '0;
                  resp_dz        <= 1'b0;
                  resp_err       <= 1'b1;
                  resp_valid     <= 1'b1;
                  state          <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
